// File: rtl/mips_multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main controller and the ALU decoder.
// Holds the state enum, the opcode constants and the ALU_OP encodings.
package mips_multicycle_ctrl_fsm_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAdr  = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExecute = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11,
        StJump    = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS datapath with a memory-ready handshake.
// Outputs are a pure decode of the current state, gated by mem_rdy and zero.
module mips_multicycle_ctrl_fsm
    import mips_multicycle_ctrl_fsm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_rdy,
    output logic [1:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            pc_en,
    output logic            ior_d,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            illegal_op
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = mem_rdy ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:   state_d = mem_rdy ? StMemWb : StMemRd;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = mem_rdy ? StFetch : StMemWr;
            StExecute: state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            StJump:    state_d = StFetch;
            default:   state_d = StIdle;
        endcase
    end

    logic pc_write;
    logic branch;

    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        ior_d      = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b = 2'b01;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                      illegal_op = 1'b1;
                endcase
            end
            StMemAdr, StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: ior_d = 1'b1;
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            StMemWr: begin
                ior_d     = 1'b1;
                mem_write = 1'b1;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            StAddiWb: reg_write = 1'b1;
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Branch resolves in the same cycle the ALU compares, so zero is used unregistered.
        pc_en = pc_write | (branch & zero);
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle phases
// and the DUT outputs are compared against a table of what each phase must drive.
module tb_mips_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       ior_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        int         fetch_waits;
        int         mem_waits;
        int         zero_sel;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_rdy;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    mips_multicycle_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .ior_d      (ior_d),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t actual();
        out_t a;
        a = '{alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ior_d, mem_write, ir_write,
              reg_write, reg_dst, mem_to_reg, illegal_op};
        return a;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // What each instruction phase must drive, straight from the control table.
    function automatic out_t model(string ph, logic z, logic rdy, logic [5:0] op);
        out_t o = '0;
        case (ph)
            "FETCH": begin
                o.alu_src_b = 2'b01;
                o.ir_write  = rdy;
                o.pc_en     = rdy;
            end
            "DECODE": begin
                o.alu_src_b  = 2'b11;
                o.illegal_op = !legal(op);
            end
            "MEMADR", "ADDIEX": begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
            end
            "MEMRD": o.ior_d = 1'b1;
            "MEMWR": begin
                o.ior_d     = 1'b1;
                o.mem_write = 1'b1;
            end
            "MEMWB": begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            "EXECUTE": begin
                o.alu_src_a = 1'b1;
                o.alu_op    = 2'b10;
            end
            "ALUWB": begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
            end
            "BRANCH": begin
                o.alu_src_a = 1'b1;
                o.alu_op    = 2'b01;
                o.pc_src    = 2'b01;
                o.pc_en     = z;
            end
            "ADDIWB": o.reg_write = 1'b1;
            "JUMP": begin
                o.pc_src = 2'b10;
                o.pc_en  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of a phase: drive after the falling edge, compare shortly after.
    task automatic step(string ph, logic [5:0] op, logic rdy, int zsel = -1);
        @(negedge clk);
        opcode  = op;
        mem_rdy = rdy;
        zero    = (zsel < 0) ? rbit() : 1'(zsel);
        #1;
        check(ph, actual(), model(ph, zero, rdy, op));
    endtask

    task automatic run_instr(logic [5:0] op, int fw, int mw, int zsel);
        for (int i = 0; i < fw; i++) step("FETCH", junk(), 1'b0);
        step("FETCH", junk(), 1'b1);
        step("DECODE", op, rbit());
        case (op)
            6'b100011: begin
                step("MEMADR", op, rbit());
                for (int i = 0; i < mw; i++) step("MEMRD", junk(), 1'b0);
                step("MEMRD", junk(), 1'b1);
                step("MEMWB", junk(), rbit());
            end
            6'b101011: begin
                step("MEMADR", op, rbit());
                for (int i = 0; i < mw; i++) step("MEMWR", junk(), 1'b0);
                step("MEMWR", junk(), 1'b1);
            end
            6'b000000: begin
                step("EXECUTE", junk(), rbit());
                step("ALUWB", junk(), rbit());
            end
            6'b000100: step("BRANCH", junk(), rbit(), zsel);
            6'b001000: begin
                step("ADDIEX", junk(), rbit());
                step("ADDIWB", junk(), rbit());
            end
            6'b000010: step("JUMP", junk(), rbit());
            default: ;
        endcase
    endtask

    vec_t vecs[$];

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

        vecs.push_back('{"rtype",        6'b000000, 0, 0, -1});
        vecs.push_back('{"lw_nowait",    6'b100011, 0, 0, -1});
        vecs.push_back('{"lw_memrd_3",   6'b100011, 2, 3, -1});
        vecs.push_back('{"sw_nowait",    6'b101011, 0, 0, -1});
        vecs.push_back('{"sw_memwr_2",   6'b101011, 1, 2, -1});
        vecs.push_back('{"beq_taken",    6'b000100, 0, 0, 1});
        vecs.push_back('{"beq_nottaken", 6'b000100, 0, 0, 0});
        vecs.push_back('{"addi",         6'b001000, 0, 0, -1});
        vecs.push_back('{"jump",         6'b000010, 0, 0, -1});
        vecs.push_back('{"illegal_3f",   6'b111111, 0, 0, -1});
        vecs.push_back('{"fetch_stall",  6'b000000, 3, 0, -1});

        rst_n   = 1'b0;
        opcode  = 6'b0;
        zero    = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", actual(), '0);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", actual(), '0);

        foreach (vecs[k]) begin
            run_instr(vecs[k].op, vecs[k].fetch_waits, vecs[k].mem_waits, vecs[k].zero_sel);
        end

        // Reset while a store is waiting for memory drops the write immediately.
        step("FETCH", junk(), 1'b1);
        step("DECODE", 6'b101011, 1'b1);
        step("MEMADR", 6'b101011, 1'b0);
        step("MEMWR", junk(), 1'b0);
        #2;
        rst_n   = 1'b0;
        mem_rdy = 1'b1;
        #1;
        check("reset_mid_memwr", actual(), '0);
        @(negedge clk);
        #1;
        check("reset_held", actual(), '0);
        rst_n = 1'b1;
        #1;
        check("idle_after_midreset", actual(), '0);
        run_instr(6'b000000, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = junk();
            else op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(0, 3)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
